// File: rtl/demux16_route_pkg.sv
// Shared definitions for the 1-to-3 routing demultiplexer: select codes,
// FSM state encoding, internal destination encoding and the select decoder.
package demux16_route_pkg;

    // Destination select codes as presented on in_sel (2'b11 aliases C)
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    // Holding-register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Decoded destination; also used as the channel index
    typedef enum logic [1:0] {
        DST_A = 2'd0,
        DST_B = 2'd1,
        DST_C = 2'd2
    } dest_e;

    // Map a raw select code onto a destination; both upper codes go to C
    function automatic dest_e decode_sel(input logic [1:0] sel);
        case (sel)
            SEL_A:   return DST_A;
            SEL_B:   return DST_B;
            default: return DST_C;
        endcase
    endfunction

endpackage

// File: rtl/demux16_route_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count up on inc, stick at all-ones, clear on request
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/demux16_route.sv
// Registered 1-to-3 demultiplexer: a single holding register captures a word
// and its destination, presents it on exactly one channel, and refills in the
// same cycle it drains so a stream can flow at one word per clock.
module demux16_route
    import demux16_route_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic [WIDTH-1:0] out_b_data,
    output logic [WIDTH-1:0] out_c_data,
    output logic             out_a_valid,
    output logic             out_b_valid,
    output logic             out_c_valid,
    input  logic             out_a_ready,
    input  logic             out_b_ready,
    input  logic             out_c_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c
);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    dest_e            dest_reg, dest_next;

    logic             dest_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic [2:0]       ch_valid;
    logic [2:0]       ch_inc;
    logic [CNT_W-1:0] ch_cnt [3];

    // Ready of whichever consumer the held word is addressed to
    always_comb begin
        case (dest_reg)
            DST_A:   dest_ready = out_a_ready;
            DST_B:   dest_ready = out_b_ready;
            default: dest_ready = out_c_ready;
        endcase
    end

    // Accept when empty or when the held word leaves this cycle; never looks at in_valid
    assign in_ready = (state_reg == ST_EMPTY) || dest_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = (state_reg == ST_FULL) && dest_ready;

    // Occupancy, held word and destination; reset drops any held word at once
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_reg <= ST_EMPTY;
            data_reg  <= '0;
            dest_reg  <= DST_A;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            dest_reg  <= dest_next;
        end
    end

    // Next state: load on any accepted word, go empty only when drained without refill
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        dest_next  = dest_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_next = ST_FULL;
                    data_next  = in_data;
                    dest_next  = decode_sel(in_sel);
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    if (in_xfer) begin
                        data_next = in_data;
                        dest_next = decode_sel(in_sel);
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Per-channel valid and delivery strobe, plus a counter for each channel
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            assign ch_valid[gi] = (state_reg == ST_FULL) && (dest_reg == dest_e'(gi));
            assign ch_inc[gi]   = ch_valid[gi] && out_xfer;

            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_f (rst_f),
                .clr   (cnt_clr),
                .inc   (ch_inc[gi]),
                .count (ch_cnt[gi])
            );
        end
    endgenerate

    // Data is only visible on the channel that is currently valid
    assign out_a_valid = ch_valid[0];
    assign out_b_valid = ch_valid[1];
    assign out_c_valid = ch_valid[2];
    assign out_a_data  = ch_valid[0] ? data_reg : '0;
    assign out_b_data  = ch_valid[1] ? data_reg : '0;
    assign out_c_data  = ch_valid[2] ? data_reg : '0;

    assign cnt_a = ch_cnt[0];
    assign cnt_b = ch_cnt[1];
    assign cnt_c = ch_cnt[2];

endmodule

// File: doc/demux16_route.md
Name: demux16_route

Overview:
- Registered 1-to-3 demultiplexer for 16-bit datapath words, the distribution-side counterpart of the 3-input 16-bit source mux.
- Accepts one word plus a 2-bit destination select over a valid/ready handshake and delivers it to exactly one of three output channels (A, B, C), each with its own valid/ready.
- Sits between the ALU/result bus and its consumers (register-file write port, memory write port, output latch).
- Keeps per-channel delivered-word counters for debug/status.

Parameters:
- WIDTH, 16, data word width.
- CNT_W, 8, width of each per-channel delivery counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_f  input  1  reset, asynchronous, active-low; one clock domain only.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination: 00 -> A, 01 -> B, 10 and 11 -> C.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block can accept a word this cycle.
- out_a_data, out_b_data, out_c_data  output  WIDTH  channel data.
- out_a_valid, out_b_valid, out_c_valid  output  1  channel word valid.
- out_a_ready, out_b_ready, out_c_ready  input  1  consumer accepts.
- cnt_clr  input  1  synchronous clear of all counters.
- cnt_a, cnt_b, cnt_c  output  CNT_W  saturating count of words delivered per channel.

Behaviour:
- Reset (rst_f low, asynchronous): state EMPTY, held data 0, held destination A.
  - All out_*_valid 0, all out_*_data 0, all cnt_* 0.
  - in_ready reads 1 once rst_f is high.
- Reset mid-operation: the held word is discarded and its valid drops immediately. It is never delivered or counted.
- State machine, two states:
  - EMPTY: nothing held.
  - FULL: one word held, destination D.
- Definitions:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_D_valid && out_D_ready.
- in_ready = (state == EMPTY) || out_D_ready. It must not depend on in_valid.
- out_X_valid = (state == FULL) && (D == X). It must not depend on out_X_ready.
- out_X_data = held data when out_X_valid, otherwise 0.
- Transitions:
  - EMPTY, input transfer -> FULL; capture in_data and decoded in_sel.
  - FULL, output transfer, no input transfer -> EMPTY.
  - FULL, output transfer and input transfer in the same cycle -> stay FULL and load the new word. Full throughput: one word per cycle sustained.
  - FULL, consumer not ready -> hold the word and destination stable. in_ready stays 0 and no new word is captured.
- Latency: a word accepted at edge N is valid on its channel after edge N; it can be consumed at edge N+1.
- Ordering: words are delivered strictly in acceptance order, including across channels (single-entry, no reordering).
- Back-pressure on one channel stalls all channels (head-of-line). This is intended.
- Counters:
  - cnt_X increments by 1 on each channel-X output transfer.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr takes priority: clear and increment in the same cycle leave 0.
- in_sel is ignored when in_valid is 0. X/Z on in_sel while in_valid=1 is a bench error.

Decomposition:
- Shared package/include holds:
  - select codes SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10 (2'b11 aliases C);
  - state encodings ST_EMPTY=1'b0, ST_FULL=1'b1.
- One natural sub-module: sat_counter (CNT_W-bit, inputs inc and clr, clr wins, saturating), instantiated three times.
- Decode and holding register stay in demux16_route.

Test Plan:
- Reset, then in_data=16'h1234, in_sel=00, in_valid pulse, out_a_ready=1 -> next cycle out_a_valid=1 with out_a_data=16'h1234; B/C valid 0 with data 0; cnt_a=1 after consumption.
- Back-pressure: send 16'hBEEF to B with out_b_ready=0 for 5 cycles -> out_b_valid stays 1 with stable data, in_ready=0 throughout. Raise ready -> one transfer, cnt_b=1, state EMPTY.
- Streaming: 8 consecutive words with sel 00,01,10,11,00,01,10,11 and all readies 1 -> one delivery per cycle in order; cnt_a=2, cnt_b=2, cnt_c=4; in_ready never 0.
- Saturation/clear: CNT_W=8, deliver 300 words to C -> cnt_c=255. Assert cnt_clr in the same cycle as a delivery -> cnt_c=0.
- Async reset mid-hold: word held for C with out_c_ready=0, pull rst_f low between clock edges -> out_c_valid falls without waiting for clk; after release no delivery occurs and cnt_c is unchanged at 0.
- Simultaneous drain and load: FULL to A with out_a_ready=1, in_valid=1 with sel=01, data 16'h0F0F -> next cycle out_b_valid=1 with 16'h0F0F and out_a_valid=0.
